// File: rtl/vp_centroid.sv
// vp_centroid: binary-mask centroid tracker with crosshair overlay.
// Ports: clk, rst, de/h_sync/v_sync/pixel in, delayed timing +
// 24-bit RGB out, centroid_x/y/valid. Optional VP_CENTROID_BBOX_EN.
module vp_centroid #(
  parameter int          X_W        = 11,
  parameter int          Y_W        = 11,
  parameter int          ACC_W      = 32,
  parameter int          MIN_AREA   = 16,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           de_in,
  input  logic           h_sync_in,
  input  logic           v_sync_in,
  input  logic [7:0]     pixel_in,
  output logic           de_out,
  output logic           h_sync_out,
  output logic           v_sync_out,
  output logic [23:0]    pixel_out,
  output logic [X_W-1:0] centroid_x,
  output logic [Y_W-1:0] centroid_y,
  output logic           centroid_valid
);

  localparam int M_W = 2 * X_W + 1;
  localparam int R_W = M_W + 1;
  localparam int C_W = $clog2(ACC_W);

  typedef enum logic [2:0] {
    ACCUM, CHECK, DIV_X, DIV_Y, UPDATE
  } state_t;

  state_t state_q, state_d;

  logic           de_q, vs_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [M_W-1:0] m00_q, s00_q;
  logic [ACC_W-1:0] m10_q, m01_q;
  logic [ACC_W-1:0] s10_q, s01_q;
  logic [ACC_W-1:0] num_q;
  logic [R_W-1:0] rem_q;
  logic [C_W-1:0] cnt_q;
  logic [X_W-1:0] qx_q, cx_q;
  logic [Y_W-1:0] cy_q;
  logic           valid_q;
  logic           de_o_q, hs_o_q, vs_o_q;
  logic [23:0]    pix_q;

  logic vs_rise, de_fall, fg, last;
  logic ld_x, ld_y, step, chk_fail, upd;
  logic hit, bb_hit;

  assign vs_rise = v_sync_in & ~vs_q;
  assign de_fall = de_q & ~de_in;
  assign fg      = de_in & pixel_in[7];
  assign last    = cnt_q == C_W'(ACC_W - 1);

  // One restoring-division step: remainder never exceeds the
  // divisor, so one extra bit is enough for the shifted value.
  logic [R_W-1:0]   rem_sh, div_ext, rem_nx;
  logic [ACC_W-1:0] quo_nx;
  logic             ge;
  logic [X_W-1:0]   sat_x;
  logic [Y_W-1:0]   sat_y;

  assign rem_sh  = {rem_q[R_W-2:0], num_q[ACC_W-1]};
  assign div_ext = {1'b0, s00_q};
  assign ge      = rem_sh >= div_ext;
  assign rem_nx  = ge ? rem_sh - div_ext : rem_sh;
  assign quo_nx  = {num_q[ACC_W-2:0], ge};

  assign sat_x = (|quo_nx[ACC_W-1:X_W]) ? '1
                                         : quo_nx[X_W-1:0];
  // Y quotient is read in UPDATE, after its final step
  assign sat_y = (|num_q[ACC_W-1:Y_W]) ? '1
                                        : num_q[Y_W-1:0];

  logic [ACC_W:0] sum10, sum01;
  assign sum10 = {1'b0, m10_q} + (ACC_W+1)'(x_q);
  assign sum01 = {1'b0, m01_q} + (ACC_W+1)'(y_q);

  always_comb begin
    state_d  = state_q;
    ld_x     = 1'b0;
    ld_y     = 1'b0;
    step     = 1'b0;
    chk_fail = 1'b0;
    upd      = 1'b0;
    unique case (state_q)
      ACCUM: ;
      CHECK: begin
        if (s00_q < M_W'(MIN_AREA)) begin
          chk_fail = 1'b1;
          state_d  = ACCUM;
        end else begin
          ld_x    = 1'b1;
          state_d = DIV_X;
        end
      end
      DIV_X: begin
        step = 1'b1;
        if (last) begin
          ld_y    = 1'b1;
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        step = 1'b1;
        if (last) state_d = UPDATE;
      end
      UPDATE: begin
        upd     = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    // new snapshot always wins; any division in flight is dropped
    if (vs_rise) begin
      state_d  = CHECK;
      ld_x     = 1'b0;
      ld_y     = 1'b0;
      step     = 1'b0;
      chk_fail = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      m00_q   <= '0;
      m10_q   <= '0;
      m01_q   <= '0;
      s00_q   <= '0;
      s10_q   <= '0;
      s01_q   <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qx_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      de_o_q  <= 1'b0;
      hs_o_q  <= 1'b0;
      vs_o_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= de_in;
      vs_q    <= v_sync_in;
      de_o_q  <= de_in;
      hs_o_q  <= h_sync_in;
      vs_o_q  <= v_sync_in;
      pix_q   <= (hit | bb_hit) ? MARK_COLOR
                                : {3{pixel_in}};

      if (de_in) begin
        if (~&x_q) x_q <= x_q + X_W'(1);
      end else if (de_fall) begin
        x_q <= '0;
      end

      if (vs_rise) y_q <= '0;
      else if (de_fall && ~&y_q) y_q <= y_q + Y_W'(1);

      if (vs_rise) begin
        s00_q <= m00_q;
        s10_q <= m10_q;
        s01_q <= m01_q;
        m00_q <= '0;
        m10_q <= '0;
        m01_q <= '0;
      end else if (fg) begin
        if (~&m00_q) m00_q <= m00_q + M_W'(1);
        m10_q <= sum10[ACC_W] ? '1 : sum10[ACC_W-1:0];
        m01_q <= sum01[ACC_W] ? '1 : sum01[ACC_W-1:0];
      end

      if (ld_x) begin
        num_q <= s10_q;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (ld_y) begin
        qx_q  <= sat_x;
        num_q <= s01_q;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        num_q <= quo_nx;
        rem_q <= rem_nx;
        cnt_q <= cnt_q + C_W'(1);
      end

      if (chk_fail) valid_q <= 1'b0;
      if (upd) begin
        cx_q    <= qx_q;
        cy_q    <= sat_y;
        valid_q <= 1'b1;
      end
    end
  end

  assign hit = valid_q & de_in & ((x_q == cx_q) | (y_q == cy_q));

`ifdef VP_CENTROID_BBOX_EN
  logic [X_W-1:0] xmin_q, xmax_q, sxmin_q, sxmax_q, bxmin_q, bxmax_q;
  logic [Y_W-1:0] ymin_q, ymax_q, symin_q, symax_q, bymin_q, bymax_q;

  // box is committed together with the centroid so an aborted
  // division cannot pair a fresh box with a stale centroid
  always_ff @(posedge clk) begin
    if (rst) begin
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      sxmin_q <= '1;
      sxmax_q <= '0;
      symin_q <= '1;
      symax_q <= '0;
      bxmin_q <= '0;
      bxmax_q <= '0;
      bymin_q <= '0;
      bymax_q <= '0;
    end else begin
      if (vs_rise) begin
        sxmin_q <= xmin_q;
        sxmax_q <= xmax_q;
        symin_q <= ymin_q;
        symax_q <= ymax_q;
        xmin_q  <= '1;
        xmax_q  <= '0;
        ymin_q  <= '1;
        ymax_q  <= '0;
      end else if (fg) begin
        if (x_q < xmin_q) xmin_q <= x_q;
        if (x_q > xmax_q) xmax_q <= x_q;
        if (y_q < ymin_q) ymin_q <= y_q;
        if (y_q > ymax_q) ymax_q <= y_q;
      end
      if (upd) begin
        bxmin_q <= sxmin_q;
        bxmax_q <= sxmax_q;
        bymin_q <= symin_q;
        bymax_q <= symax_q;
      end
    end
  end

  logic in_x, in_y, on_x, on_y;
  assign in_x = (x_q >= bxmin_q) & (x_q <= bxmax_q);
  assign in_y = (y_q >= bymin_q) & (y_q <= bymax_q);
  assign on_x = (x_q == bxmin_q) | (x_q == bxmax_q);
  assign on_y = (y_q == bymin_q) | (y_q == bymax_q);
  assign bb_hit = valid_q & de_in & ((on_x & in_y) | (on_y & in_x));
`else
  assign bb_hit = 1'b0;
`endif

  assign de_out         = de_o_q;
  assign h_sync_out     = hs_o_q;
  assign v_sync_out     = vs_o_q;
  assign pixel_out      = pix_q;
  assign centroid_x     = cx_q;
  assign centroid_y     = cy_q;
  assign centroid_valid = valid_q;

endmodule

// File: tb/tb_vp_centroid.sv
// tb_vp_centroid: directed frames for vp_centroid (MIN_AREA=4).
// Drives 64x64 frames, checks centroid timing/values and overlay.
module tb_vp_centroid;

  localparam int BLACK  = 0;
  localparam int SQUARE = 1;
  localparam int BLOCK  = 2;
  localparam int TRIPLE = 3;

  logic        clk = 1'b0;
  logic        rst, de, hs, vs;
  logic [7:0]  pix;
  logic        de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_out;
  logic [10:0] centroid_x, centroid_y;
  logic        centroid_valid;

  int passed = 0;
  int total  = 0;
  logic vs_seen;
  logic [23:0] cap [0:63][0:63];

  always #5 clk = ~clk;

  vp_centroid #(
    .X_W(11), .Y_W(11), .ACC_W(32),
    .MIN_AREA(4), .MARK_COLOR(24'hFF0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .de_in(de),
    .h_sync_in(hs),
    .v_sync_in(vs),
    .pixel_in(pix),
    .de_out(de_out),
    .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out),
    .pixel_out(pixel_out),
    .centroid_x(centroid_x),
    .centroid_y(centroid_y),
    .centroid_valid(centroid_valid)
  );

  function automatic bit fg(input int m, input int x, input int y);
    case (m)
      SQUARE: return x >= 8 && x <= 15 && y >= 4 && y <= 11;
      BLOCK:  return x >= 10 && x <= 11 && y >= 20 && y <= 21;
      TRIPLE: return (y == 20 && (x == 10 || x == 11)) ||
                     (y == 21 && x == 10);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lines(input int m);
    for (int y = 0; y < 64; y++) begin
      de = 0; pix = 0; hs = 0; tick;
      hs = 1; tick;
      hs = 0; tick; tick;
      for (int x = 0; x < 64; x++) begin
        de = 1;
        pix = fg(m, x, y) ? 8'hFF : 8'h00;
        tick;
        cap[y][x] = pixel_out;
      end
      de = 0; pix = 0;
    end
    repeat (4) tick;
  endtask

  task automatic vsync_pulse;
    vs = 1; tick;
    vs_seen = v_sync_out;
    tick;
    vs = 0;
  endtask

  task automatic chk_c(input string nm, input logic [10:0] ex,
                       input logic [10:0] ey, input logic ev);
    total++;
    if ({centroid_x, centroid_y, centroid_valid} !== {ex, ey, ev})
      $display("FAIL %s: got x=%0d y=%0d v=%0b, want x=%0d y=%0d v=%0b",
               nm, centroid_x, centroid_y, centroid_valid, ex, ey, ev);
    else passed++;
  endtask

  task automatic chk_p(input string nm, input int x, input int y,
                       input logic [23:0] e);
    total++;
    if (cap[y][x] !== e)
      $display("FAIL %s (%0d,%0d): got %h want %h", nm, x, y,
               cap[y][x], e);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1; de = 0; hs = 0; vs = 0; pix = 0;
    repeat (2) tick;
    total++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out, centroid_x,
         centroid_y, centroid_valid} !== '0)
      $display("FAIL reset_init: outputs not zero");
    else passed++;
    rst = 0;
    lines(SQUARE);
    vsync_pulse;
    repeat (20) tick;
    de = 1; pix = 8'hFF; hs = 1; rst = 1;
    tick; tick;
    total++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out, centroid_x,
         centroid_y, centroid_valid} !== '0)
      $display("FAIL reset_mid: got de=%b px=%h v=%b want zeros",
               de_out, pixel_out, centroid_valid);
    else passed++;
    rst = 0; de = 0; pix = 0; hs = 0;
    repeat (70) tick;
    chk_c("reset_discard", 11'd0, 11'd0, 1'b0);
    lines(SQUARE);
    chk_p("reset_no_ovl_fg", 8, 4, 24'hFFFFFF);
    chk_p("reset_no_ovl_c", 11, 7, 24'hFFFFFF);
    chk_p("reset_no_ovl_col", 11, 0, 24'h000000);
    chk_p("reset_no_ovl_row", 0, 7, 24'h000000);
  endtask

  task automatic test_square;
    vsync_pulse;
    total++;
    if (vs_seen !== 1'b1)
      $display("FAIL vsync_delay: got %b want 1", vs_seen);
    else passed++;
    repeat (64) tick;
    chk_c("square_t65", 11'd0, 11'd0, 1'b0);
    tick;
    chk_c("square_t66", 11'd11, 11'd7, 1'b1);
    lines(BLOCK);
    chk_p("sq_col", 11, 30, 24'hFF0000);
    chk_p("sq_row", 40, 7, 24'hFF0000);
    chk_p("sq_cross", 11, 7, 24'hFF0000);
    chk_p("sq_fg", 10, 20, 24'hFFFFFF);
    chk_p("sq_bg", 40, 40, 24'h000000);
`ifdef VP_CENTROID_BBOX_EN
    chk_p("bbox_l", 8, 6, 24'hFF0000);
    chk_p("bbox_r", 15, 9, 24'hFF0000);
    chk_p("bbox_t", 13, 4, 24'hFF0000);
    chk_p("bbox_b", 9, 11, 24'hFF0000);
    chk_p("bbox_in", 9, 6, 24'h000000);
`endif
  endtask

  task automatic test_crosshair;
    vsync_pulse;
    repeat (65) tick;
    chk_c("block_c", 11'd10, 11'd20, 1'b1);
    lines(BLACK);
    chk_p("x_col", 10, 0, 24'hFF0000);
    chk_p("x_row", 63, 20, 24'hFF0000);
    chk_p("x_ctr", 10, 20, 24'hFF0000);
    chk_p("x_off", 11, 22, 24'h000000);
  endtask

  task automatic test_black;
    int bad;
    vsync_pulse;
    chk_c("black_fail", 11'd10, 11'd20, 1'b0);
    repeat (65) tick;
    chk_c("black_hold", 11'd10, 11'd20, 1'b0);
    lines(BLACK);
    bad = 0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        if (cap[y][x] !== 24'h0) bad++;
    total++;
    if (bad != 0)
      $display("FAIL black_frame: got %0d nonzero pixels want 0", bad);
    else passed++;
  endtask

  task automatic test_min_area;
    vsync_pulse;
    repeat (65) tick;
    lines(TRIPLE);
    vsync_pulse;
    repeat (65) tick;
    chk_c("area_3", 11'd10, 11'd20, 1'b0);
    lines(BLOCK);
    vsync_pulse;
    repeat (65) tick;
    chk_c("area_4", 11'd10, 11'd20, 1'b1);
  endtask

  task automatic test_back_to_back;
    lines(SQUARE);
    vsync_pulse;
    repeat (65) tick;
    chk_c("b2b_pre", 11'd11, 11'd7, 1'b1);
    lines(BLOCK);
    vsync_pulse;
    de = 1; pix = 8'hFF;
    repeat (4) tick;
    de = 0; pix = 0;
    repeat (4) tick;
    vsync_pulse;
    repeat (64) tick;
    chk_c("b2b_hold", 11'd11, 11'd7, 1'b1);
    tick;
    chk_c("b2b_new", 11'd1, 11'd0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_square;
    test_crosshair;
    test_black;
    test_min_area;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
